// File: rtl/hex_display_scan.sv
// Four-digit multiplexed hex driver for a 7-segment display. A shadow copy of the
// value is taken once per scan frame, and each digit slot opens with a blanking dwell.
module hex_display_scan #(
    parameter int SCAN_DIV       = 50_000,
    parameter int BLANK_CYCLES   = 1_000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1,
    parameter bit LZ_BLANK       = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_value,
    input  logic [3:0]  i_dp,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic [3:0]  o_anode,
    output logic        o_frame
);

    localparam int              CNT_W     = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [6:0]      SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic            DP_OFF    = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [3:0]      ANODE_OFF = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

    // Hex font, active-high {g,f,e,d,c,b,a}.
    function automatic logic [6:0] font(input logic [3:0] nib);
        case (nib)
            4'h0:    font = 7'h3F;
            4'h1:    font = 7'h06;
            4'h2:    font = 7'h5B;
            4'h3:    font = 7'h4F;
            4'h4:    font = 7'h66;
            4'h5:    font = 7'h6D;
            4'h6:    font = 7'h7D;
            4'h7:    font = 7'h07;
            4'h8:    font = 7'h7F;
            4'h9:    font = 7'h6F;
            4'hA:    font = 7'h77;
            4'hB:    font = 7'h7C;
            4'hC:    font = 7'h39;
            4'hD:    font = 7'h5E;
            4'hE:    font = 7'h79;
            4'hF:    font = 7'h71;
            default: font = 7'h00;
        endcase
    endfunction

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [15:0]      r_shadow_val;
    logic [3:0]       r_shadow_dp;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic [3:0]       r_anode;
    logic             r_frame;

    logic             w_last;
    logic             w_capture;
    logic [3:0]       w_nibble;
    logic [3:0]       w_lz;
    logic             w_enable;
    logic [6:0]       w_seg_nxt;
    logic             w_dp_nxt;
    logic [3:0]       w_anode_nxt;

    assign w_last    = (r_cnt == CNT_MAX);
    assign w_capture = w_last && (r_idx == 2'd3);
    assign w_nibble  = r_shadow_val[{r_idx, 2'b00} +: 4];

    // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 never is.
    assign w_lz[3] = (r_shadow_val[15:12] == 4'h0);
    assign w_lz[2] = w_lz[3] && (r_shadow_val[11:8] == 4'h0);
    assign w_lz[1] = w_lz[2] && (r_shadow_val[7:4] == 4'h0);
    assign w_lz[0] = 1'b0;

    assign w_enable = (r_cnt >= BLANK_END) && !(LZ_BLANK && w_lz[r_idx]);

    // Next pin values for the current slot state, with polarity applied.
    always_comb begin
        w_seg_nxt   = SEG_OFF;
        w_dp_nxt    = DP_OFF;
        w_anode_nxt = ANODE_OFF;
        if (w_enable) begin
            w_seg_nxt   = SEG_ACTIVE_LOW ? ~font(w_nibble) : font(w_nibble);
            w_dp_nxt    = SEG_ACTIVE_LOW ? ~r_shadow_dp[r_idx] : r_shadow_dp[r_idx];
            w_anode_nxt = DIG_ACTIVE_LOW ? ~(4'b0001 << r_idx) : (4'b0001 << r_idx);
        end else begin
            w_seg_nxt   = SEG_OFF;
            w_dp_nxt    = DP_OFF;
            w_anode_nxt = ANODE_OFF;
        end
    end

    // Slot counter, digit index and once-per-frame shadow capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= 2'd0;
            r_shadow_val <= 16'h0000;
            r_shadow_dp  <= 4'h0;
        end else begin
            if (w_last) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_capture) begin
                r_shadow_val <= i_value;
                r_shadow_dp  <= i_dp;
            end
        end
    end

    // Output registers; reset forces every pin to its inactive level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg   <= SEG_OFF;
            r_dp    <= DP_OFF;
            r_anode <= ANODE_OFF;
            r_frame <= 1'b0;
        end else begin
            r_seg   <= w_seg_nxt;
            r_dp    <= w_dp_nxt;
            r_anode <= w_anode_nxt;
            r_frame <= w_capture;
        end
    end

    assign o_seg   = r_seg;
    assign o_dp    = r_dp;
    assign o_anode = r_anode;
    assign o_frame = r_frame;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan: three instances (plain, leading-zero blanking,
// active-high polarities) share clock, reset and input stimulus.
module tb_hex_display_scan;

    logic        clk;
    logic        rst_n;
    logic [15:0] i_value;
    logic [3:0]  i_dp;

    logic [6:0]  a_seg, b_seg, c_seg;
    logic        a_dp, b_dp, c_dp;
    logic [3:0]  a_anode, b_anode, c_anode;
    logic        a_frame, b_frame, c_frame;

    int n_checks;
    int n_fail;
    int cyc;

    hex_display_scan #(.SCAN_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1),
                       .DIG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .i_value(i_value), .i_dp(i_dp),
        .o_seg(a_seg), .o_dp(a_dp), .o_anode(a_anode), .o_frame(a_frame));

    hex_display_scan #(.SCAN_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1),
                       .DIG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .i_value(i_value), .i_dp(i_dp),
        .o_seg(b_seg), .o_dp(b_dp), .o_anode(b_anode), .o_frame(b_frame));

    hex_display_scan #(.SCAN_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b0),
                       .DIG_ACTIVE_LOW(1'b0), .LZ_BLANK(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .i_value(i_value), .i_dp(i_dp),
        .o_seg(c_seg), .o_dp(c_dp), .o_anode(c_anode), .o_frame(c_frame));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int k);
        while (cyc < k) tick();
    endtask

    initial begin
        int off_cnt;
        int t;
        logic [3:0] exp_an;

        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        i_value  = 16'h12AF;
        i_dp     = 4'b0001;

        // Reset held: everything inactive.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_a_anode", a_anode, 4'hF);
        check_eq("rst_a_seg",   a_seg,   7'h7F);
        check_eq("rst_a_dp",    a_dp,    1'b1);
        check_eq("rst_a_frame", a_frame, 1'b0);
        check_eq("rst_c_anode", c_anode, 4'h0);
        check_eq("rst_c_seg",   c_seg,   7'h00);

        // First frame pulse 32 cycles after release.
        rst_n = 1'b1;
        cyc   = 0;
        while (!a_frame && cyc < 100) tick();
        check_eq("first_frame_delay", cyc, 32);
        check_eq("first_frame_b", b_frame, 1'b1);
        check_eq("first_frame_c", c_frame, 1'b1);

        // 0x12AF, dp on digit 0.
        wait_to(33);
        check_eq("d0_blank0", a_anode, 4'hF);
        wait_to(34);
        check_eq("d0_blank1", a_anode, 4'hF);
        check_eq("d0_blank_seg", a_seg, 7'h7F);
        wait_to(35);
        check_eq("d0_anode", a_anode, 4'b1110);
        check_eq("d0_seg_F", a_seg, 7'h0E);
        check_eq("d0_dp", a_dp, 1'b0);
        check_eq("d0_frame_low", a_frame, 1'b0);
        wait_to(59);
        check_eq("d3_anode", a_anode, 4'b0111);
        check_eq("d3_seg_1", a_seg, 7'h79);
        check_eq("d3_dp", a_dp, 1'b1);
        wait_to(63);
        check_eq("frame_pre", a_frame, 1'b0);
        wait_to(64);
        check_eq("frame_period", a_frame, 1'b1);

        // Full frame of scan timing: 2 dark cycles then one anode per slot.
        off_cnt = 0;
        for (int j = 65; j <= 96; j++) begin
            wait_to(j);
            t = (j - 1) % 32;
            exp_an = ((t % 8) < 2) ? 4'hF : ~(4'b0001 << (t / 8));
            check_eq("scan_anode", a_anode, exp_an);
            if (a_anode == 4'hF) off_cnt++;
        end
        check_eq("scan_off_cycles", off_cnt, 8);

        // 0x1234 captured at 128; 0xBEEF arrives mid-frame and waits for 160.
        i_value = 16'h1234;
        i_dp    = 4'b0000;
        wait_to(131);
        check_eq("tear_d0_4", a_seg, 7'h19);
        i_value = 16'hBEEF;
        wait_to(139);
        check_eq("tear_d1_3", a_seg, 7'h30);
        wait_to(147);
        check_eq("tear_d2_2", a_seg, 7'h24);
        wait_to(155);
        check_eq("tear_d3_1", a_seg, 7'h79);
        wait_to(163);
        check_eq("new_d0_F", a_seg, 7'h0E);
        wait_to(171);
        check_eq("new_d1_E", a_seg, 7'h06);
        wait_to(179);
        check_eq("new_d2_E", a_seg, 7'h06);
        wait_to(187);
        check_eq("new_d3_b", a_seg, 7'h03);

        // Leading-zero blanking with 0x0040 (captured at 192).
        i_value = 16'h0040;
        wait_to(195);
        check_eq("lz_d0_anode", b_anode, 4'b1110);
        check_eq("lz_d0_seg", b_seg, 7'h40);
        i_value = 16'h0000;
        i_dp    = 4'b1111;
        wait_to(203);
        check_eq("lz_d1_anode", b_anode, 4'b1101);
        check_eq("lz_d1_seg", b_seg, 7'h19);
        wait_to(211);
        check_eq("lz_d2_dark", b_anode, 4'hF);
        wait_to(219);
        check_eq("lz_d3_dark", b_anode, 4'hF);
        check_eq("lz_d3_seg", b_seg, 7'h7F);
        check_eq("nolz_d3_anode", a_anode, 4'b0111);
        check_eq("nolz_d3_seg0", a_seg, 7'h40);

        // 0x0000 with all dp bits set (captured at 224).
        wait_to(225);
        check_eq("c_blank_anode", c_anode, 4'h0);
        check_eq("c_blank_seg", c_seg, 7'h00);
        wait_to(227);
        check_eq("lz0_d0_anode", b_anode, 4'b1110);
        check_eq("lz0_d0_seg", b_seg, 7'h40);
        check_eq("lz0_d0_dp", b_dp, 1'b0);
        check_eq("c_d0_anode", c_anode, 4'b0001);
        check_eq("c_d0_seg", c_seg, 7'h3F);
        check_eq("c_d0_dp", c_dp, 1'b1);
        i_value = 16'hABCD;
        i_dp    = 4'b0000;
        wait_to(235);
        check_eq("lz0_d1_dark", b_anode, 4'hF);
        check_eq("lz0_d1_dp_dark", b_dp, 1'b1);

        // Reset during digit 2 of the 0xABCD frame (captured at 256).
        wait_to(275);
        check_eq("pre_rst_d2_anode", a_anode, 4'b1011);
        check_eq("pre_rst_d2_seg_b", a_seg, 7'h03);
        check_eq("pre_rst_c_anode", c_anode, 4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_a_anode", a_anode, 4'hF);
        check_eq("async_rst_a_seg", a_seg, 7'h7F);
        check_eq("async_rst_a_dp", a_dp, 1'b1);
        check_eq("async_rst_c_anode", c_anode, 4'h0);
        check_eq("async_rst_c_seg", c_seg, 7'h00);
        check_eq("async_rst_c_dp", c_dp, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        cyc   = 0;
        wait_to(3);
        check_eq("restart_d0_anode", a_anode, 4'b1110);
        check_eq("restart_d0_seg0", a_seg, 7'h40);
        check_eq("restart_d0_dp", a_dp, 1'b1);
        check_eq("restart_c_anode", c_anode, 4'b0001);
        check_eq("restart_c_seg0", c_seg, 7'h3F);
        wait_to(31);
        check_eq("restart_frame_pre", a_frame, 1'b0);
        wait_to(32);
        check_eq("restart_frame", a_frame, 1'b1);
        wait_to(35);
        check_eq("restart_new_d0_D", a_seg, 7'h21);
        check_eq("restart_c_new_d0_D", c_seg, 7'h5E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
